// File: rtl/tick_prescaler_pkg.sv
// Shared types and constants for the tick prescaler.
// Provides the FSM state enum and default divide settings.
package tick_prescaler_pkg;

  localparam int unsigned DIV_W_DEF = 24;
  localparam logic [DIV_W_DEF-1:0] DEFAULT_DIV_DEF = 24'd12_500_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

endpackage

// File: rtl/tick_prescaler_rise_edge_detect.sv
// Rising-edge detector for a synchronous level input.
// Ports: clk, rst (sync, active high), d (level) -> pulse (d rose).
module rise_edge_detect
  import tick_prescaler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = d;
    pulse  = d & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/tick_prescaler.sv
// Clock prescaler producing a one-cycle tick enable with run/stop/step.
// Ports: clk, rst (sync high), run, step, div -> tick, running, phase.
// Define TICK_PRESCALER_STEP_EN to compile in single-step support.
module tick_prescaler
  import tick_prescaler_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(DEFAULT_DIV_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             running,
  output logic [DIV_W-1:0] phase
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] RST_RATIO =
    (DEFAULT_DIV == '0) ? ONE : DEFAULT_DIV;

  state_t           state_q, state_d;
  logic             tick_q, tick_d;
  logic             running_q, running_d;
  logic [DIV_W-1:0] phase_q, phase_d;
  logic [DIV_W-1:0] ratio_q, ratio_d;
  logic [DIV_W-1:0] div_eff;
  logic             wrap;
  logic             step_rise;

`ifdef TICK_PRESCALER_STEP_EN
  rise_edge_detect u_step_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (step),
    .pulse (step_rise)
  );
`else
  logic unused_step;
  assign unused_step = step;
  assign step_rise   = 1'b0;
`endif

  assign div_eff = (div == '0) ? ONE : div;
  assign wrap    = (phase_q == ratio_q - ONE);

  always_comb begin
    state_d = state_q;
    tick_d  = 1'b0;
    phase_d = phase_q;
    ratio_d = ratio_q;
    unique case (state_q)
      IDLE: begin
        ratio_d = div_eff;
        phase_d = '0;
        if (run) begin
          // The sampling cycle counts as phase 0 of
          // the first period, so RUN starts at 1.
          state_d = RUN;
          if (div_eff == ONE) begin
            tick_d = 1'b1;
          end else begin
            phase_d = ONE;
          end
        end else if (step_rise) begin
          state_d = STEP;
          tick_d  = 1'b1;
        end
      end
      RUN: begin
        if (!run) begin
          state_d = IDLE;
          phase_d = '0;
        end else if (wrap) begin
          phase_d = '0;
          tick_d  = 1'b1;
          ratio_d = div_eff;
        end else begin
          phase_d = phase_q + ONE;
        end
      end
`ifdef TICK_PRESCALER_STEP_EN
      STEP: begin
        state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      phase_q   <= '0;
      ratio_q   <= RST_RATIO;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      running_q <= running_d;
      phase_q   <= phase_d;
      ratio_q   <= ratio_d;
    end
  end

  assign tick    = tick_q;
  assign running = running_q;
  assign phase   = phase_q;

endmodule

// File: tb/tb_tick_prescaler.sv
// Scoreboard bench for tick_prescaler against a period-counting model.
// Honours TICK_PRESCALER_STEP_EN the same way as the design.
module tb_tick_prescaler;

  typedef struct packed {
    logic        tick;
    logic        running;
    logic [23:0] phase;
  } exp_t;

`ifdef TICK_PRESCALER_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [23:0] div = 24'd0;
  logic        tick;
  logic        running;
  logic [23:0] phase;

  int   checks = 0;
  int   failures = 0;
  int   ncyc = 0;
  exp_t sb_q[$];
  bit   stim_done = 1'b0;

  int m_mode = M_IDLE;
  int m_el = 0;
  int m_ratio = 1;
  bit m_prev = 1'b0;
  bit m_tick = 1'b0;

  tick_prescaler dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .step    (step),
    .div     (div),
    .tick    (tick),
    .running (running),
    .phase   (phase)
  );

  always #5 clk = ~clk;

  // Elapsed-cycles view: a period is 'ratio' edges long,
  // counted from the edge that sampled run (or the last tick).
  task automatic model_edge(input bit r, input bit rn,
                            input bit st, input logic [23:0] d);
    int dv;
    bit rise;
    dv = (d == 24'd0) ? 1 : int'(d);
    rise = st && !m_prev;
    m_prev = st;
    m_tick = 1'b0;
    if (r) begin
      m_mode = M_IDLE;
      m_el = 0;
      m_prev = 1'b0;
    end else if (m_mode == M_IDLE) begin
      if (rn) begin
        m_mode = M_RUN;
        m_ratio = dv;
        m_el = 1;
        if (m_el == m_ratio) begin
          m_tick = 1'b1;
          m_el = 0;
        end
      end else if (rise && STEP_EN) begin
        m_mode = M_STEP;
        m_tick = 1'b1;
      end
    end else if (m_mode == M_RUN) begin
      if (!rn) begin
        m_mode = M_IDLE;
        m_el = 0;
      end else begin
        m_el++;
        if (m_el == m_ratio) begin
          m_tick = 1'b1;
          m_el = 0;
          m_ratio = dv;
        end
      end
    end else begin
      m_mode = M_IDLE;
    end
    sb_q.push_back('{m_tick, (m_mode == M_RUN), 24'(m_el)});
  endtask

  task automatic cyc(input bit r, input bit rn,
                     input bit st, input logic [23:0] d);
    @(negedge clk);
    rst = r;
    run = rn;
    step = st;
    div = d;
    model_edge(r, rn, st, d);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        ncyc++;
        checks++;
        if (tick !== e.tick) begin
          failures++;
          $display("FAIL tick cyc=%0d got=%0b exp=%0b",
                   ncyc, tick, e.tick);
        end
        checks++;
        if (running !== e.running) begin
          failures++;
          $display("FAIL running cyc=%0d got=%0b exp=%0b",
                   ncyc, running, e.running);
        end
        checks++;
        if (phase !== e.phase) begin
          failures++;
          $display("FAIL phase cyc=%0d got=%0d exp=%0d",
                   ncyc, phase, e.phase);
        end
      end
    end
  end

  initial begin
    bit r_rn;
    bit r_st;
    logic [23:0] r_dv;
    // reset
    cyc(1, 0, 0, 4);
    cyc(1, 0, 0, 4);
    // div=4 free run
    for (int i = 0; i < 14; i++) cyc(0, 1, 0, 4);
    cyc(0, 0, 0, 4);
    cyc(0, 0, 0, 0);
    // div=0 behaves as 1
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 5);
    // mid-period ratio change
    cyc(0, 1, 0, 5);
    for (int i = 0; i < 10 && m_el != 1; i++) cyc(0, 1, 0, 5);
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 2);
    cyc(0, 0, 0, 3);
    // run dropped on the wrap cycle
    cyc(0, 1, 0, 3);
    for (int i = 0; i < 10 && m_el != m_ratio - 1; i++)
      cyc(0, 1, 0, 3);
    cyc(0, 0, 0, 3);
    cyc(0, 0, 0, 3);
    // step held high
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 3);
    cyc(0, 0, 0, 3);
    cyc(0, 0, 0, 3);
    // step and run rising together
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 3);
    cyc(0, 0, 0, 3);
    cyc(0, 0, 0, 3);
    // step then run
    cyc(0, 0, 1, 2);
    cyc(0, 1, 0, 2);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 2);
    cyc(0, 0, 0, 6);
    // reset mid-run at phase 3
    cyc(0, 1, 0, 6);
    for (int i = 0; i < 10 && m_el != 3; i++) cyc(0, 1, 0, 6);
    cyc(1, 1, 0, 6);
    cyc(0, 0, 0, 6);
    // randomized traffic
    r_rn = 1'b0;
    r_st = 1'b0;
    r_dv = 24'd3;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 24) == 0) r_rn = ~r_rn;
      if ($urandom_range(0, 5) == 0) r_st = ~r_st;
      if ($urandom_range(0, 39) == 0)
        r_dv = 24'($urandom_range(0, 6));
      cyc(($urandom_range(0, 299) == 0), r_rn, r_st, r_dv);
    end
    cyc(0, 0, 0, 3);
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
